rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Write-side companion to the 32x32 register file; the single producer of WrEn_RF, WAddr_RF and WD_RF.
- Merges two result sources into the register file's one write port:
  - ALU results: one per cycle, no backpressure.
  - Load-unit responses: valid/ready handshake, buffered in a small FIFO.
- Drops writes to x0 and guarantees forward progress for loads with a starvation-driven pipeline stall.

Parameters:
- LQ_DEPTH, 4, load FIFO entries (power of 2, >=2)
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before a stall is forced (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- AluValid_WB  input  1  ALU result present this cycle
- AluAddr_WB  input  5  ALU destination register
- AluData_WB  input  32  ALU result
- LdValid_WB  input  1  load response valid
- LdReady_WB  output  1  FIFO can accept load response
- LdAddr_WB  input  5  load destination register
- LdData_WB  input  32  load data, already extended
- AluStall_WB  output  1  request upstream to suppress AluValid_WB next cycle
- WrEn_RF  output  1  register-file write enable
- WAddr_RF  output  5  register-file write address
- WD_RF  output  32  register-file write data

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0 and in the first cycle after it:
  - WrEn_RF=0, WAddr_RF=0, WD_RF=0, AluStall_WB=0, LdReady_WB=1.
  - FIFO empty, wait counter 0, state NORMAL.
  - Reset mid-operation discards all FIFO contents with no write emitted.
- Output timing: WrEn_RF, WAddr_RF and WD_RF are registered. A source selected in cycle N produces the write in cycle N+1 for exactly 1 cycle.
- x0 filter: a selected entry with address 0 is consumed (popped, or ALU accepted) but WrEn_RF stays 0. The address/data registers may still update.
- Load FIFO:
  - LdReady_WB = !full, derived from registered state.
  - A push occurs when LdValid_WB && LdReady_WB.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - No pop when empty. Pointers wrap modulo LQ_DEPTH.
  - Occupancy counter is clog2(LQ_DEPTH)+1 bits.
  - A push into an empty FIFO is not poppable until the next cycle (no FIFO bypass).
- Arbitration priority:
  1. AluValid_WB.
  2. FIFO head, if non-empty.
  3. Idle: WrEn_RF=0.
- State machine:
  - NORMAL:
    - Wait counter increments when the FIFO is non-empty and the ALU wins.
    - Wait counter clears on any pop or when the FIFO is empty.
    - When the counter would reach MAX_WAIT: go to STALL and register AluStall_WB=1.
  - STALL:
    - AluStall_WB=1. Upstream must hold AluValid_WB=0.
    - FIFO head is popped and written. Counter clears. Next state NORMAL; AluStall_WB deasserts.
    - If AluValid_WB=1 in STALL (protocol violation): the ALU still wins, state remains STALL, and a sticky internal error flag sets (simulation assertion).
- Ordering: no same-register ordering is enforced between sources; the issue logic guarantees no WAW hazard.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - Adds outputs FwdValid_WB (1), FwdAddr_WB (5) and FwdData_WB (32).
  - These are combinational copies of the selected source in cycle N, one cycle ahead of WrEn_RF.
  - FwdValid_WB is 0 for x0 and when idle.
  - Used by the execute-stage bypass mux.
- Undefined: the ports do not exist and the logic is absent; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg holds:
  - REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0.
  - wb_state_t enum {NORMAL, STALL}.
- One sub-module, wb_load_fifo: parameterised sync FIFO with push/pop/full/empty/head, async active-low reset. The arbiter, counter, FSM and output registers stay in rf_writeback.

Test Plan:
- ALU only: AluValid=1, Addr=5, Data=0xDEADBEEF in cycle 10 -> WrEn_RF=1, WAddr_RF=5, WD_RF=0xDEADBEEF in cycle 11 only; LdReady stays 1.
- x0 drop: ALU Addr=0, Data=0x1234, and a load Addr=0 -> WrEn_RF never asserts; FIFO returns to empty.
- FIFO full: hold AluValid=1 continuously, push 4 loads -> LdReady=0 after the 4th push. A 5th LdValid is not accepted. Ordering after drain is preserved (addresses 1,2,3,4).
- Starvation: FIFO holds 1 entry, AluValid=1 for 8 cycles -> AluStall_WB=1 for 1 cycle. With AluValid dropped, the load (Addr=7, Data=0xA5A5A5A5) is written the next cycle and the counter resets.
- Simultaneous push/pop at occupancy 2 -> occupancy stays 2 and LdReady stays 1.
- Reset mid-drain: 3 entries queued, pulse rst_n low asynchronously between edges -> outputs go to 0 immediately, no further writes, LdReady=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file writeback types and widths.
package rv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } wb_state_t;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous load-response FIFO; head is readable the cycle after a push (no bypass).
module wb_load_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head_c,
    output logic    full_q,
    output logic    empty_q
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_d, empty_d;
    logic          do_push, do_pop;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_writeback.sv
// Register-file write port arbiter: ALU results beat buffered loads, with a
// starvation stall that forces a load through. Optional bypass outputs under
// RF_WB_FWD_EN.
module rf_writeback
    import rv_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AluValid_WB,
    input  logic [4:0]  AluAddr_WB,
    input  logic [31:0] AluData_WB,
    input  logic        LdValid_WB,
    output logic        LdReady_WB,
    input  logic [4:0]  LdAddr_WB,
    input  logic [31:0] LdData_WB,
    output logic        AluStall_WB,
`ifdef RF_WB_FWD_EN
    output logic        FwdValid_WB,
    output logic [4:0]  FwdAddr_WB,
    output logic [31:0] FwdData_WB,
`endif
    output logic        WrEn_RF,
    output logic [4:0]  WAddr_RF,
    output logic [31:0] WD_RF
);

    localparam int unsigned WW = $clog2(MAX_WAIT);

    wb_state_t             state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wd_q, wd_d;

    wb_req_t               fifo_head;
    wb_req_t               ld_req;
    logic                  fifo_full, fifo_empty;
    logic                  ld_push, ld_win, sel_live, sel_wr;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    assign ld_req     = '{addr: LdAddr_WB, data: LdData_WB};
    assign ld_push    = LdValid_WB && !fifo_full;
    assign LdReady_WB = !fifo_full;

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_push),
        .push_data (ld_req),
        .pop       (ld_win),
        .head_c    (fifo_head),
        .full_q    (fifo_full),
        .empty_q   (fifo_empty)
    );

    // Source select: ALU first, then FIFO head; x0 is consumed without a write.
    always_comb begin
        ld_win   = !AluValid_WB && !fifo_empty;
        sel_live = AluValid_WB || ld_win;
        sel_addr = AluValid_WB ? AluAddr_WB : fifo_head.addr;
        sel_data = AluValid_WB ? AluData_WB : fifo_head.data;
        sel_wr   = sel_live && (sel_addr != REG_ZERO);
    end

    // Starvation FSM next-state plus write-port register inputs.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        stall_d = 1'b0;
        err_d   = err_q;
        wr_en_d = sel_wr;
        waddr_d = sel_live ? sel_addr : waddr_q;
        wd_d    = sel_live ? sel_data : wd_q;
        case (state_q)
            NORMAL: begin
                if (fifo_empty || ld_win) begin
                    wait_d = '0;
                end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    state_d = STALL;
                    stall_d = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            STALL: begin
                if (AluValid_WB) begin
                    // Upstream ignored the stall: ALU still wins, keep stalling.
                    stall_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = NORMAL;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                wait_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            wait_q  <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
        end
    end

    assign AluStall_WB = stall_q;
    assign WrEn_RF     = wr_en_q;
    assign WAddr_RF    = waddr_q;
    assign WD_RF       = wd_q;

`ifdef RF_WB_FWD_EN
    assign FwdValid_WB = sel_wr;
    assign FwdAddr_WB  = sel_addr;
    assign FwdData_WB  = sel_data;
`endif

    stall_protocol_a: assert property (@(posedge clk) disable iff (!rst_n) !err_q);

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios plus randomized traffic against a queue model.
module tb_rf_writeback;

    localparam int unsigned LQ_DEPTH = 4;
    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        AluValid_WB = 1'b0;
    logic [4:0]  AluAddr_WB = '0;
    logic [31:0] AluData_WB = '0;
    logic        LdValid_WB = 1'b0;
    logic        LdReady_WB;
    logic [4:0]  LdAddr_WB = '0;
    logic [31:0] LdData_WB = '0;
    logic        AluStall_WB;
    logic        WrEn_RF;
    logic [4:0]  WAddr_RF;
    logic [31:0] WD_RF;
`ifdef RF_WB_FWD_EN
    logic        FwdValid_WB;
    logic [4:0]  FwdAddr_WB;
    logic [31:0] FwdData_WB;
`endif

    rf_writeback #(.LQ_DEPTH(LQ_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .AluValid_WB (AluValid_WB),
        .AluAddr_WB  (AluAddr_WB),
        .AluData_WB  (AluData_WB),
        .LdValid_WB  (LdValid_WB),
        .LdReady_WB  (LdReady_WB),
        .LdAddr_WB   (LdAddr_WB),
        .LdData_WB   (LdData_WB),
        .AluStall_WB (AluStall_WB),
`ifdef RF_WB_FWD_EN
        .FwdValid_WB (FwdValid_WB),
        .FwdAddr_WB  (FwdAddr_WB),
        .FwdData_WB  (FwdData_WB),
`endif
        .WrEn_RF     (WrEn_RF),
        .WAddr_RF    (WAddr_RF),
        .WD_RF       (WD_RF)
    );

    always #5 clk = ~clk;

    // Model: pending loads in arrival order, count of lost arbitrations, expected outputs.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        ldq[$];
    int          starve;
    logic        m_stall;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ldq.delete();
        starve  = 0;
        m_stall = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld);
        int          occ = ldq.size();
        bit          sel = 1'b0;
        bit          popped = 1'b0;
        logic [4:0]  sa = '0;
        logic [31:0] sd = '0;
        if (av) begin
            sel = 1'b1; sa = aa; sd = ad;
        end else if (occ > 0) begin
            sel = 1'b1; sa = ldq[0].addr; sd = ldq[0].data;
            void'(ldq.pop_front());
            popped = 1'b1;
        end
        m_wr = sel && (sa != 5'd0);
        if (sel) begin
            m_addr = sa;
            m_data = sd;
        end
        if (m_stall) begin
            if (!av) begin
                m_stall = 1'b0;
                starve  = 0;
            end
        end else if (occ == 0 || popped) begin
            starve = 0;
        end else begin
            starve++;
            if (starve == int'(MAX_WAIT)) begin
                m_stall = 1'b1;
                starve  = 0;
            end
        end
        if (lv && occ < int'(LQ_DEPTH)) ldq.push_back('{addr: la, data: ld});
    endtask

    task automatic check_outputs();
        chk("wren", 32'(WrEn_RF), 32'(m_wr));
        if (m_wr) begin
            chk("waddr", 32'(WAddr_RF), 32'(m_addr));
            chk("wdata", WD_RF, m_data);
        end
        chk("ldready", 32'(LdReady_WB), 32'(ldq.size() < int'(LQ_DEPTH)));
        chk("stall", 32'(AluStall_WB), 32'(m_stall));
    endtask

    // Apply one cycle of inputs, step the model, check outputs 1 time unit after the edge.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        AluValid_WB = av; AluAddr_WB = aa; AluData_WB = ad;
        LdValid_WB  = lv; LdAddr_WB  = la; LdData_WB  = ld;
        model_step(av, aa, ad, lv, la, ld);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_wren"}, 32'(WrEn_RF), 32'd0);
        chk({tag, "_waddr"}, 32'(WAddr_RF), 32'd0);
        chk({tag, "_wd"}, WD_RF, 32'd0);
        chk({tag, "_stall"}, 32'(AluStall_WB), 32'd0);
        chk({tag, "_ldready"}, 32'(LdReady_WB), 32'd1);
    endtask

    initial begin
        // Reset state.
        model_reset();
        @(posedge clk);
        #1;
        check_reset_literals("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
        idle(7);

        // ALU only: one write, exactly one cycle.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("alu_wren", 32'(WrEn_RF), 32'd1);
        chk("alu_waddr", 32'(WAddr_RF), 32'd5);
        chk("alu_wd", WD_RF, 32'hDEADBEEF);
        chk("alu_ldready", 32'(LdReady_WB), 32'd1);
        idle(1);
        chk("alu_wren_off", 32'(WrEn_RF), 32'd0);

        // x0 drop from both sources.
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55);
        chk("x0_alu", 32'(WrEn_RF), 32'd0);
        idle(1);
        chk("x0_ld", 32'(WrEn_RF), 32'd0);
        idle(1);
        chk("x0_idle", 32'(WrEn_RF), 32'd0);
        chk("x0_empty", 32'(ldq.size()), 32'd0);

        // FIFO full under continuous ALU traffic, then ordered drain.
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 5'd10, 32'(k), 1'b1, 5'(k), 32'h100 + 32'(k));
            chk("full_ready", 32'(LdReady_WB), (k == 4) ? 32'd0 : 32'd1);
        end
        cycle(1'b1, 5'd10, 32'd5, 1'b1, 5'd5, 32'h105);
        chk("full_reject", 32'(LdReady_WB), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk("drain_wren", 32'(WrEn_RF), 32'd1);
            chk("drain_addr", 32'(WAddr_RF), 32'(k));
            chk("drain_ready", 32'(LdReady_WB), 32'd1);
        end
        idle(1);
        chk("drain_done", 32'(WrEn_RF), 32'd0);

        // Starvation: one queued load loses to the ALU 8 times, then is forced through.
        cycle(1'b1, 5'd3, 32'd0, 1'b1, 5'd7, 32'hA5A5A5A5);
        chk("starve_stall0", 32'(AluStall_WB), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 5'd3, 32'(k), 1'b0, 5'd0, 32'd0);
            chk("starve_stall", 32'(AluStall_WB), (k == 8) ? 32'd1 : 32'd0);
        end
        idle(1);
        chk("starve_wren", 32'(WrEn_RF), 32'd1);
        chk("starve_addr", 32'(WAddr_RF), 32'd7);
        chk("starve_wd", WD_RF, 32'hA5A5A5A5);
        chk("starve_release", 32'(AluStall_WB), 32'd0);
        cycle(1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 32'd0);
        chk("starve_clear", 32'(AluStall_WB), 32'd0);

        // Push and pop together at occupancy 2.
        cycle(1'b1, 5'd4, 32'd0, 1'b1, 5'd20, 32'h20);
        cycle(1'b1, 5'd4, 32'd0, 1'b1, 5'd21, 32'h21);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h22);
        chk("pp_addr", 32'(WAddr_RF), 32'd20);
        chk("pp_ready", 32'(LdReady_WB), 32'd1);
        chk("pp_occ", 32'(ldq.size()), 32'd2);
        idle(1);
        chk("pp_addr21", 32'(WAddr_RF), 32'd21);
        idle(1);
        chk("pp_addr22", 32'(WAddr_RF), 32'd22);
        idle(1);

        // Asynchronous reset mid-drain.
        for (int k = 1; k <= 3; k++) cycle(1'b1, 5'd9, 32'd0, 1'b1, 5'(k + 10), 32'(k));
        idle(1);
        chk("mid_wren", 32'(WrEn_RF), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_literals("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("post_rst_wren", 32'(WrEn_RF), 32'd0);
        end

        // Randomized traffic; upstream honours the stall.
        for (int i = 0; i < 800; i++) begin
            int   pct = ((i / 100) % 2 == 1) ? 95 : 50;
            logic av  = !m_stall && ($urandom_range(0, 99) < pct);
            logic lv  = ($urandom_range(0, 99) < 45);
            cycle(av, 5'($urandom_range(0, 31)), $urandom(), lv, 5'($urandom_range(0, 31)), $urandom());
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
